// File: rtl/weight_loader_if.sv
// Host-side weight row write channel for the weight loader.
// One row of 5-bit encoded weights per accepted transfer.
interface weight_loader_if #(
  parameter int SIZE = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [5*SIZE-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/weight_loader.sv
// Buffers a SIZE x SIZE weight tile and shifts it into the PE array top row.
// WEIGHT_LOADER_PINGPONG_EN adds a second bank so filling overlaps streaming.
module weight_loader #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  weight_loader_if.slave    wr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [5*SIZE-1:0] Weight_out,
  output logic              Weight_out_valid
);
  localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [RW-1:0] LAST = RW'(SIZE - 1);

  typedef enum logic [1:0] {FILL, FULL, LOAD} state_t;
  state_t state, state_n;

  logic [RW-1:0]     wr_row, ld_row, rd_sel;
  logic [5*SIZE-1:0] rd_word;
  logic              accept, fill_last, launch, finish, more;

  assign accept    = wr.wr_valid && wr.wr_ready && !rst;
  assign fill_last = accept && (wr_row == LAST);
  assign launch    = start && (state == FULL) && !rst;
  assign finish    = (state == LOAD) && (ld_row == '0);
  assign rd_sel    = launch ? LAST : ld_row - RW'(1);
  assign busy      = Weight_out_valid;

`ifdef WEIGHT_LOADER_PINGPONG_EN
  logic              fill_bank, rd_bank;
  logic [1:0]        bank_full;
  logic [5*SIZE-1:0] tile [2][SIZE];

  assign wr.wr_ready = !bank_full[fill_bank];
  assign more        = bank_full[~rd_bank] || fill_last;
  assign rd_word     = tile[rd_bank][rd_sel];

  always_ff @(posedge clk) begin
    if (accept) tile[fill_bank][wr_row] <= wr.wr_data;
  end

  // Banks alternate, so streaming order always matches fill order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_bank <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
    end else begin
      if (fill_last) begin
        bank_full[fill_bank] <= 1'b1;
        fill_bank            <= ~fill_bank;
      end
      if (finish) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
    end
  end
`else
  logic [5*SIZE-1:0] tile [SIZE];

  assign wr.wr_ready = (state == FILL);
  assign more        = 1'b0;
  assign rd_word     = tile[rd_sel];

  always_ff @(posedge clk) begin
    if (accept) tile[wr_row] <= wr.wr_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FILL:    if (fill_last) state_n = FULL;
      FULL:    if (launch)    state_n = LOAD;
      LOAD:    if (finish)    state_n = more ? FULL : FILL;
      default: state_n = FILL;
    endcase
  end

  // Bottom row goes out first so row r lands in PE row r after SIZE shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_row           <= '0;
      ld_row           <= '0;
      done             <= 1'b0;
      Weight_out       <= '0;
      Weight_out_valid <= 1'b0;
    end else begin
      done <= finish;
      if (accept) wr_row <= fill_last ? '0 : wr_row + RW'(1);
      if (launch) begin
        Weight_out       <= rd_word;
        Weight_out_valid <= 1'b1;
        ld_row           <= LAST;
      end else if (state == LOAD) begin
        if (finish) begin
          Weight_out       <= '0;
          Weight_out_valid <= 1'b0;
        end else begin
          Weight_out <= rd_word;
          ld_row     <= rd_sel;
        end
      end
    end
  end
endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: rows queued at start, popped on valid.
// Set WEIGHT_LOADER_PINGPONG_EN to exercise the two-bank build.
module tb_weight_loader;
  localparam int SIZE = 8;
  localparam int W = 5 * SIZE;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, Weight_out_valid;
  logic [W-1:0] Weight_out;

  weight_loader_if #(.SIZE(SIZE)) wr();

  weight_loader #(.SIZE(SIZE)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr               (wr),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .Weight_out       (Weight_out),
    .Weight_out_valid (Weight_out_valid)
  );

  always #5 clk = ~clk;

  int           errs = 0;
  int           checks = 0;
  int           done_cnt = 0;
  int           vcnt = 0;
  int           psum = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] q[$];
  logic [W-1:0] mtile [2][SIZE];
  logic [W-1:0] pe [SIZE];
  int           mrow = 0;
  int           mfill = 0;
  int           mrd = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(int r, int seed);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < SIZE; c++) v[5*c +: 5] = 5'((r * 8 + c + seed) % 32);
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_cnt++;
      if (Weight_out_valid) begin
        vcnt++;
        if (q.size() == 0) chk("unexp_valid", 1, 0);
        else chk("row_data", Weight_out, q.pop_front());
      end else begin
        chk("idle_zero", Weight_out, 0);
      end
    end
  end

  always @(posedge clk) begin
    if (Weight_out_valid) begin
      for (int r = SIZE - 1; r > 0; r--) pe[r] <= pe[r-1];
      pe[0] <= Weight_out;
    end else begin
      psum <= psum + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    mrow = 0;
    mfill = 0;
    mrd = 0;
    q.delete();
  endtask

  task automatic model_store(logic [W-1:0] d);
    mtile[mfill][mrow] = d;
    mrow++;
    if (mrow == SIZE) begin
      mrow = 0;
`ifdef WEIGHT_LOADER_PINGPONG_EN
      mfill ^= 1;
`endif
    end
  endtask

  task automatic write_row(logic [W-1:0] d);
    logic rdy;
    rdy = 1'b0;
    wr.wr_valid = 1'b1;
    wr.wr_data = d;
    for (int i = 0; i < 60 && !rdy; i++) begin
      rdy = wr.wr_ready;
      step();
    end
    wr.wr_valid = 1'b0;
    chk("write_accept", rdy, 1);
    if (rdy) model_store(d);
  endtask

  task automatic fill(int seed, int n);
    for (int r = 0; r < n; r++) write_row(pat(r, seed));
  endtask

  task automatic push_tile();
    for (int r = SIZE - 1; r >= 0; r--) q.push_back(mtile[mrd][r]);
`ifdef WEIGHT_LOADER_PINGPONG_EN
    mrd ^= 1;
`endif
  endtask

  task automatic do_start();
    push_tile();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_load();
    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk);
      chk("ld_valid", Weight_out_valid, 1);
      chk("ld_busy", busy, 1);
      chk("ld_no_done", done, 0);
      step();
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_valid_low", Weight_out_valid, 0);
    chk("done_ready", wr.wr_ready, 1);
    step();
    @(negedge clk);
    chk("done_once", done, 0);
    step();
  endtask

  task automatic wait_done(int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      step();
      n++;
    end
    chk("done_seen", done_cnt != d0, 1);
  endtask

  initial begin
    int d0, v0, p0, acc;
    wr.wr_valid = 1'b0;
    wr.wr_data = '0;
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", wr.wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", Weight_out_valid, 0);
    chk("rst_out", Weight_out, 0);
    step();

    // basic load plus PE array view
    fill(0, SIZE);
`ifndef WEIGHT_LOADER_PINGPONG_EN
    chk("full_ready", wr.wr_ready, 0);
`endif
    do_start();
    check_load();
    for (int r = 0; r < SIZE; r++) chk("pe_row", pe[r], mtile[0][r]);
    p0 = psum;
    repeat (3) step();
    chk("psum_runs", psum - p0, 3);

    // start in FILL is ignored
    fill(3, 5);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fill_start_ignored", Weight_out_valid, 0);
      step();
    end
    chk("fill_ready", wr.wr_ready, 1);

`ifndef WEIGHT_LOADER_PINGPONG_EN
    do_reset();
    acc = 0;
    wr.wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr.wr_data = pat(i, 5);
      if (i == 8) chk("bp_ready9", wr.wr_ready, 0);
      if (wr.wr_ready) begin
        model_store(wr.wr_data);
        acc++;
      end
      step();
    end
    wr.wr_valid = 1'b0;
    chk("bp_accepted", acc, SIZE);
    do_start();
    check_load();
`endif

    // reset on the fourth LOAD cycle
    do_reset();
    fill(9, SIZE);
    do_start();
    repeat (3) step();
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", Weight_out_valid, 0);
    chk("abort_out", Weight_out, 0);
    chk("abort_ready", wr.wr_ready, 1);
    chk("abort_rows", q.size(), SIZE - 4);
    q.delete();
    mrow = 0;
    mfill = 0;
    mrd = 0;
    repeat (12) step();
    chk("abort_no_done", done_cnt - d0, 0);
    fill(11, SIZE);
`ifndef WEIGHT_LOADER_PINGPONG_EN
    chk("refill_full", wr.wr_ready, 0);
`endif
    do_start();
    check_load();

    // start held high through FULL and LOAD
    fill(13, SIZE);
    d0 = done_cnt;
    v0 = vcnt;
    push_tile();
    start = 1'b1;
    repeat (24) step();
    start = 1'b0;
    chk("held_valids", vcnt - v0, SIZE);
    chk("held_dones", done_cnt - d0, 1);

`ifdef WEIGHT_LOADER_PINGPONG_EN
    do_reset();
    fill(17, SIZE);
    d0 = done_cnt;
    do_start();
    fill(21, SIZE);
    wait_done(d0);
    d0 = done_cnt;
    do_start();
    wait_done(d0);
    step();
    fill(1, SIZE);
    fill(2, SIZE);
    chk("pp_both_full", wr.wr_ready, 0);
    d0 = done_cnt;
    do_start();
    wait_done(d0);
    d0 = done_cnt;
    do_start();
    wait_done(d0);
    step();
`endif

    chk("q_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 The module SHALL have parameter SIZE, default 8, meaning PE array rows and columns.
REQ-002 The module SHALL have port clk, input, 1 bit, meaning the single clock; all logic updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, meaning reset: synchronous, active-high.
REQ-004 The module SHALL have port wr_valid, input, 1 bit, meaning a host weight row is offered.
REQ-005 The module SHALL have port wr_ready, output, 1 bit, meaning the loader accepts a row this cycle.
REQ-006 The module SHALL have port wr_data, input, 5*SIZE bits, meaning one encoded weight row; bits [5c+4:5c] belong to column c.
REQ-007 The module SHALL have port start, input, 1 bit, meaning a request to stream the stored tile into the array.
REQ-008 The module SHALL have port busy, output, 1 bit, meaning streaming is in progress.
REQ-009 The module SHALL have port done, output, 1 bit, meaning a one-cycle pulse after the tile is streamed.
REQ-010 The module SHALL have port Weight_out, output, 5*SIZE bits, meaning it drives the top-row PE Weight_in per column.
REQ-011 The module SHALL have port Weight_out_valid, output, 1 bit, meaning it drives the top-row PE Weight_in_valid.

Function
REQ-012 The loader SHALL store SIZE rows, indexed 0 (top PE row) to SIZE-1 in host write order, in a tile buffer of SIZE x 5*SIZE bits.
REQ-013 A row SHALL be accepted exactly on a cycle with wr_valid=1 and wr_ready=1; the row index counter increments and does not wrap past SIZE-1.
REQ-014 The FSM SHALL have three states: FILL, FULL and LOAD.
REQ-015 In FILL, wr_ready SHALL be 1; accepting row SIZE-1 SHALL move the FSM to FULL.
REQ-016 In FULL, wr_ready SHALL be 0, and start=1 SHALL move the FSM to LOAD.
REQ-017 In LOAD, the FSM SHALL hold for exactly SIZE cycles and then return to FILL with the row counter at 0.
REQ-018 start SHALL be ignored in FILL and LOAD, with no queuing.
REQ-019 Timing: start sampled in FULL at edge t SHALL drive Weight_out_valid=1 on cycles t+1..t+SIZE.
REQ-020 LOAD cycle k (k=0..SIZE-1) SHALL emit row SIZE-1-k, so that after SIZE shifts PE row r holds row r.
REQ-021 busy SHALL be 1 exactly while Weight_out_valid=1.
REQ-022 done SHALL be 1 for exactly cycle t+SIZE+1, the same cycle in which wr_ready returns to 1.
REQ-023 When Weight_out_valid=0, Weight_out SHALL be all zeros, and Weight_out_valid SHALL never assert outside LOAD, because PE accumulation is frozen while it is high.
REQ-024 Weight_out and Weight_out_valid SHALL be registered outputs with no combinational path from any input.
REQ-025 Weight data SHALL pass through unmodified: no re-encoding and no sign handling.

Reset
REQ-026 On rst=1 at a clock edge, the following SHALL take effect after that edge: FSM to FILL, row counter 0, wr_ready=1, busy=0, done=0, Weight_out=0, Weight_out_valid=0.
REQ-027 Tile buffer contents SHALL NOT be reset and SHALL be treated as invalid.
REQ-028 Reset during LOAD SHALL abort streaming from the next cycle, with no done pulse; the array weights are then undefined until the next full load.
REQ-029 rst SHALL take priority over wr_valid and start in the same cycle.

Configuration
REQ-030 With macro WEIGHT_LOADER_PINGPONG_EN defined, the loader SHALL hold two tile banks.
- The host fills one bank while the other is FULL or in LOAD.
- wr_ready SHALL be 0 only when both banks are full, or when the fill bank is full and the other bank is loading.
- start SHALL be honoured whenever the FSM is not in LOAD and at least one bank is full; banks are streamed in fill order.
- After LOAD the FSM SHALL go to FULL if the other bank is full, else to FILL.
- Bank write and bank stream in the same cycle SHALL both succeed.
REQ-031 Without WEIGHT_LOADER_PINGPONG_EN, the single-bank behaviour of REQ-012..REQ-025 SHALL apply and no second bank is synthesized.

Verification
REQ-032 Scenario, basic load, SIZE=8: write rows with column c of row r = (r*8+c) mod 32, then pulse start.
- Weight_out_valid is high for 8 cycles, emitting rows 7,6,...,0.
- done is high on the cycle after the last valid, and wr_ready then rises.
REQ-033 Scenario, backpressure: assert wr_valid for 10 cycles.
- Only 8 rows are accepted and wr_ready=0 from the 9th cycle.
- A start pulse in FILL after 5 rows produces no valid output.
REQ-034 Scenario, reset mid-load: assert rst on the 4th LOAD cycle.
- Weight_out_valid=0 and Weight_out=0 from the next cycle; no done pulse.
- wr_ready=1 and the row counter is 0.
REQ-035 Scenario, start held high continuously through FULL and LOAD: exactly one LOAD of 8 cycles and one done pulse occur.
REQ-036 Scenario, PINGPONG_EN: fill bank A, start, and fill bank B during the LOAD of A; then start again.
- B streams 8 cycles, beginning 2 cycles after A's final valid at the earliest.
- No row is lost or duplicated.
REQ-037 Scenario, array check: attach an 8x8 PE model and load the tile of REQ-032.
- Every PE holds its expected weight.
- With Weight_out_valid low, partial sums accumulate again.
